// File: rtl/instr_sequencer.sv
// Instruction-issuing front end for the 16-bit multi-cycle processor: holds a
// small {ir, din} program and drives it through the run/done handshake.
module instr_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [24:0]       prog_data,
  input  logic              start,
  input  logic              done,
  output logic [8:0]        ir,
  output logic [15:0]       din,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t           state, state_next;
  logic [24:0]      mem [PROG_DEPTH];
  logic [24:0]      fetch_word;
  logic [WD_W-1:0]  watchdog;
  logic             fetch_halt;
  logic             last_pc;
  logic             wd_expired;
  logic             addr_ok;

  always_comb begin
    fetch_word = mem[pc];
    fetch_halt = (fetch_word[24:22] == 3'b111);
    last_pc    = (pc == ADDR_W'(PROG_DEPTH - 1));
    wd_expired = (watchdog == WD_W'(TIMEOUT - 1));
    addr_ok    = ({1'b0, prog_addr} < (ADDR_W + 1)'(PROG_DEPTH));
  end

  // Status outputs are pure state decodes, so reset clears run asynchronously.
  always_comb begin
    run    = (state == S_ISSUE);
    busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
    halted = (state == S_HALT);
    error  = (state == S_ERROR);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALT, S_ERROR: if (start) state_next = S_FETCH;
      S_FETCH: state_next = fetch_halt ? S_HALT : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (done)            state_next = last_pc ? S_HALT : S_FETCH;
        else if (wd_expired) state_next = S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      din         <= '0;
      instr_count <= '0;
      watchdog    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        S_FETCH: begin
          // A halt word is never presented, so ir/din keep the last issued instruction.
          if (!fetch_halt) begin
            ir  <= fetch_word[24:16];
            din <= fetch_word[15:0];
          end
        end
        S_ISSUE: watchdog <= '0;
        S_WAIT: begin
          if (done) begin
            if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
            if (!last_pc) pc <= pc + ADDR_W'(1);
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (prog_we && !busy && addr_ok) mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level reference model predicts
// the issued instruction stream and final status; a monitor checks each run pulse.
module tb_instr_sequencer;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [24:0] prog_data;
  logic        start;
  logic        done;
  logic        proc_done = 1'b0;
  logic        stim_done;
  logic [8:0]  ir;
  logic [15:0] din;
  logic        run;
  logic [3:0]  pc;
  logic [7:0]  instr_count;
  logic        busy;
  logic        halted;
  logic        error;

  typedef struct packed {
    logic [8:0]  ir;
    logic [15:0] din;
    logic [3:0]  pc;
  } issue_t;

  issue_t      exp_q[$];
  logic [24:0] mdl_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          drop_pc = -1;
  int          last_run_cyc = 0;
  int          err_rise_cyc = 0;
  bit          exp_err_v;
  int          exp_pc_v;
  int          exp_cnt_v;

  assign done = proc_done | stim_done;

  instr_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .done(done), .ir(ir), .din(din),
    .run(run), .pc(pc), .instr_count(instr_count), .busy(busy),
    .halted(halted), .error(error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-level reference: walk the program word by word, no cycle detail.
  function automatic void model_run(input int dp, output bit e_err, output int e_pc, output int e_cnt);
    int p = 0;
    int cnt = 0;
    logic [24:0] w;
    issue_t it;
    e_err = 1'b0;
    for (int step = 0; step < DEPTH; step++) begin
      w = mdl_mem[p];
      if (w[24:22] == 3'b111) break;
      it.ir = w[24:16];
      it.din = w[15:0];
      it.pc = 4'(p);
      exp_q.push_back(it);
      if (p == dp) begin
        e_err = 1'b1;
        break;
      end
      cnt = (cnt < 255) ? cnt + 1 : 255;
      if (p == DEPTH - 1) break;
      p++;
    end
    e_pc = p;
    e_cnt = cnt;
  endfunction

  // Processor model: MV/MVI-style ops answer 1 cycle after run, ADD/SUB after 3.
  initial begin
    int lat;
    forever begin
      @(negedge clock);
      if (run && !reset && int'(pc) != drop_pc) begin
        lat = (ir[8:6] == 3'b010 || ir[8:6] == 3'b011) ? 3 : 1;
        repeat (lat) @(posedge clock);
        #1 proc_done = 1'b1;
        @(posedge clock);
        #1 proc_done = 1'b0;
      end
    end
  end

  initial begin
    bit prev_run = 1'b0;
    bit prev_err = 1'b0;
    issue_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_run = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (run) begin
          chk("run_gap", 32'(prev_run), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_run_pc", 32'(pc), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("issue_ir", 32'(ir), 32'(e.ir));
            chk("issue_din", 32'(din), 32'(e.din));
            chk("issue_pc", 32'(pc), 32'(e.pc));
          end
          last_run_cyc = cyc;
        end
        if (error && !prev_err) err_rise_cyc = cyc;
        prev_run = run;
        prev_err = error;
      end
    end
  end

  task automatic write_word(input int a, input logic [24:0] d);
    @(posedge clock);
    #1 prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
    mdl_mem[a] = d;
    @(posedge clock);
    #1 prog_we = 1'b0;
  endtask

  task automatic load_base();
    logic [24:0] base [5];
    base[0] = {9'b001000000, 16'h0002};
    base[1] = {9'b000001000, 16'h0000};
    base[2] = {9'b010001001, 16'h0000};
    base[3] = {9'b011001000, 16'h0000};
    base[4] = {9'b111000000, 16'h0000};
    for (int a = 0; a < DEPTH; a++)
      write_word(a, (a < 5) ? base[a] : 25'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ir"}, 32'(ir), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
    chk({tag, "_run"}, 32'(run), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Returns at the falling edge inside the first ISSUE cycle.
  task automatic start_run(input int dp);
    bit ee;
    int ep, ec, s;
    bit found = 1'b0;
    int lat = -1;
    drop_pc = dp;
    model_run(dp, ee, ep, ec);
    exp_err_v = ee; exp_pc_v = ep; exp_cnt_v = ec;
    @(posedge clock);
    #1 start = 1'b1;
    s = cyc;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (run) begin
        found = 1'b1;
        lat = cyc - s;
      end
    end
    chk("start_to_run", 32'(lat), 32'd2);
  endtask

  task automatic finish_run(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      if (halted || error) ok = 1'b1;
    end
    chk({tag, "_end_reached"}, 32'(ok), 32'd1);
    chk({tag, "_halted"}, 32'(halted), 32'(!exp_err_v));
    chk({tag, "_error"}, 32'(error), 32'(exp_err_v));
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc_v));
    chk({tag, "_count"}, 32'(instr_count), 32'(exp_cnt_v));
    chk({tag, "_run"}, 32'(run), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; stim_done = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_outputs("reset");

    load_base();
    start_run(-1);
    finish_run("base");

    start_run(1);
    finish_run("timeout");
    chk("timeout_latency", 32'(err_rise_cyc - last_run_cyc), 32'(TIMEOUT + 1));
    start_run(-1);
    chk("restart_error_clear", 32'(error), 32'd0);
    finish_run("restart");

    start_run(-1);
    @(posedge clock);
    #1 prog_we = 1'b1; prog_addr = 4'd2; prog_data = '1;
    chk("busy_during_write", 32'(busy), 32'd1);
    @(posedge clock);
    #1 prog_we = 1'b0;
    finish_run("busy_write");

    for (int a = 0; a < DEPTH; a++)
      write_word(a, {3'($urandom_range(0, 6)), 22'($urandom)});
    start_run(-1);
    finish_run("full_mem");

    load_base();
    start_run(-1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_in_issue");
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 stim_done = 1'b1;
    @(posedge clock);
    #1 stim_done = 1'b0;
    check_reset_outputs("done_in_idle");

    start_run(-1);
    stim_done = 1'b1;
    @(posedge clock);
    #1 stim_done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (run && pc == 4'd2) found = 1'b1;
    end
    chk("reached_pc2", 32'(found), 32'd1);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    finish_run("ignored_strobes");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issuing front end for the 16-bit multi-cycle processor.
- Holds a small program memory of {ir, din} words.
- On start, feeds one instruction at a time into the processor's ir/din/run inputs. Waits for the processor's done before issuing the next instruction.
- Acts as the initiator side of the run/done handshake, with a watchdog for a processor that never answers.

Parameters:
- PROG_DEPTH, 16, number of program words.
- ADDR_W, 4, program address width; must satisfy 2**ADDR_W >= PROG_DEPTH.
- TIMEOUT, 16, maximum number of WAIT cycles without done before flagging an error.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  25  program word: [24:16] = ir (III XXX YYY), [15:0] = din.
- start  in  1  begin execution from address 0.
- done  in  1  processor completion strobe.
- ir  out  9  instruction to the processor.
- din  out  16  immediate data to the processor.
- run  out  1  one-cycle issue strobe.
- pc  out  ADDR_W  address of the current instruction.
- instr_count  out  8  number of completed instructions; saturates at 255.
- busy  out  1  high in FETCH, ISSUE and WAIT.
- halted  out  1  high in HALT.
- error  out  1  high in ERROR.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; pc=0; ir=0; din=0; run=0; instr_count=0; busy=0; halted=0; error=0; watchdog=0. Program memory contents are not reset.
- Memory write: prog_we writes mem[prog_addr] on the edge, only when busy=0. Writes while busy are ignored. Writes with prog_addr >= PROG_DEPTH are ignored.
- Memory read: synchronous read of mem[pc] during FETCH.
- FSM states: IDLE, FETCH, ISSUE, WAIT, HALT, ERROR.
- IDLE, HALT or ERROR with start=1 on an edge: pc=0, instr_count=0, error=0, next state FETCH. start is ignored in all other states.
- FETCH: the edge latches mem[pc] into the instruction register.
  - Opcode [24:22]=111 → HALT; nothing is issued.
  - Otherwise → ISSUE.
- ISSUE: lasts exactly one cycle.
  - run=1; ir and din are driven from the instruction register.
  - done is ignored in this state.
  - Next state WAIT; watchdog=0.
- WAIT: run=0; ir and din are held stable until the next FETCH completes.
  - done=1 on an edge: instr_count increments (saturating at 255).
    - If pc == PROG_DEPTH-1 → HALT, and pc is held.
    - Otherwise pc increments → FETCH.
  - No done: watchdog increments. When the watchdog reaches TIMEOUT-1 without done → ERROR.
  - done takes priority over timeout on the same edge.
- HALT: halted=1, busy=0, run=0; ir, din and pc hold their last values.
- ERROR: error=1, busy=0, run=0; held until start or reset.
- Timing: start sampled on edge E0 → run=1 during the cycle after E1.
  - Minimum per-instruction period is 3 cycles (FETCH, ISSUE, one WAIT cycle).
  - run is never asserted in two consecutive cycles.
- Reset asserted mid-instruction: run drops immediately (asynchronously); everything returns to the reset state.
- done outside WAIT has no effect.

Test Plan:
- Load a 5-word program: {001000000, 0x0002}, {000001000, 0x0000}, {010001001, 0x0000}, {011001000, 0x0000}, {111000000, 0x0000}. Pulse start; the model processor returns done 1 cycle after run (MV/MVI) or 3 cycles after run (ADD/SUB).
  - run pulses exactly 4 times, with ir = 0x040, 0x008, 0x089, 0x0C8 and din=0x0002 on the first.
  - halted=1 with pc=4 and instr_count=4.
- Same program, but the processor model never asserts done on the 2nd instruction.
  - error=1 exactly TIMEOUT cycles after the WAIT state is entered.
  - pc=1, instr_count=1, run=0.
  - Then pulse start → execution restarts at pc=0 and error=0.
- Full memory with no 111 opcode.
  - Halts after 16 instructions with pc=15 and instr_count=16.
- Assert prog_we to address 2 with 0x1FFFFFF while busy.
  - Memory is unchanged: rerun shows ir=0x089 at pc=2.
- Assert reset during ISSUE.
  - run=0 in the same cycle; outputs go to reset values.
  - A start after release re-runs the program correctly.
- Pulse done during IDLE and ISSUE, and pulse start during WAIT.
  - No change to pc, instr_count or state.
